// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher
// Takes one valid/ready input stream and hands each word to one of four
// output channels, chosen round-robin among the enabled channels. The output
// stage is registered: a shared data bus, a one-hot per-channel valid and the
// demux select. A word waiting too long for its channel is dropped and an
// error pulse is raised.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      input word
//   in_valid     input word present
//   in_ready     block accepts the input word this cycle (combinational)
//   ch_en        per-channel enable mask for arbitration
//   out_ready    per-channel sink ready
//   out_valid    one-hot valid to the granted channel, zero when empty
//   out_data     shared registered data bus
//   sel          index of the granted channel
//   xfer_cnt     count of completed output transfers (wraps)
//   timeout_err  one-cycle pulse when a held word is dropped
module demux_rr_dispatcher #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ch_en,
    input  logic [3:0]        out_ready,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic [15:0]       xfer_cnt,
    output logic              timeout_err
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : {WAIT_W{1'b0}};

    // First enabled channel searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    // Scanning from the far end lets the nearest enabled channel win.
    function automatic logic [1:0] pick_target(input logic [1:0] ptr, input logic [3:0] en);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (en[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [15:0]         xfer_cnt_q, xfer_cnt_d;
    logic                timeout_err_q, timeout_err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic                fire_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                timeout_hit_s;
    logic [1:0]          target_s;

    // Handshake, arbitration and next-state computation.
    always_comb begin
        fire_s        = |(out_valid_q & out_ready);
        in_ready_s    = (ch_en != 4'b0000) && ((state_q == ST_EMPTY) || fire_s);
        accept_s      = in_valid && in_ready_s;
        target_s      = pick_target(ptr_q, ch_en);
        timeout_hit_s = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        xfer_cnt_d    = xfer_cnt_q;
        timeout_err_d = 1'b0;
        wait_d        = wait_q;

        case (state_q)
            ST_EMPTY: begin
                state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (fire_s) begin
                    xfer_cnt_d  = xfer_cnt_q + 16'd1;
                    state_d     = ST_EMPTY;
                    out_valid_d = 4'b0000;
                end else if (timeout_hit_s) begin
                    // Drop the held word; ptr already points past it.
                    state_d       = ST_EMPTY;
                    out_valid_d   = 4'b0000;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d     = ST_EMPTY;
                out_valid_d = 4'b0000;
            end
        endcase

        // Accept is only possible when empty or draining, so loading here
        // overrides the empty/drain result above for back-to-back words.
        if (accept_s) begin
            state_d     = ST_FULL;
            out_data_d  = in_data;
            out_valid_d = 4'b0001 << target_s;
            sel_d       = target_s;
            ptr_d       = target_s + 2'd1;
            wait_d      = {WAIT_W{1'b0}};
        end else begin
            ptr_d = ptr_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            out_valid_q   <= 4'b0000;
            out_data_q    <= {DATA_W{1'b0}};
            sel_q         <= 2'd0;
            ptr_q         <= 2'd0;
            xfer_cnt_q    <= 16'd0;
            timeout_err_q <= 1'b0;
            wait_q        <= {WAIT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            sel_q         <= sel_d;
            ptr_q         <= ptr_d;
            xfer_cnt_q    <= xfer_cnt_d;
            timeout_err_q <= timeout_err_d;
            wait_q        <= wait_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign sel         = sel_q;
    assign xfer_cnt    = xfer_cnt_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Self-checking bench for demux_rr_dispatcher (TIMEOUT=4). Expected
// channel/data pairs are queued when a word is accepted and compared when
// the DUT fires the word to a sink.
module tb_demux_rr_dispatcher;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ch_en;
    logic [3:0]  out_ready;
    logic [3:0]  out_valid;
    logic [7:0]  out_data;
    logic [1:0]  sel;
    logic [15:0] xfer_cnt;
    logic        timeout_err;

    demux_rr_dispatcher #(.DATA_W(8), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ch_en       (ch_en),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .sel         (sel),
        .xfer_cnt    (xfer_cnt),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [1:0]  exp_ptr  = 2'd0;
    logic [15:0] exp_xfer = 16'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference round-robin choice: forward scan from the pointer.
    function automatic logic [1:0] model_target(input logic [1:0] ptr, input logic [3:0] en);
        logic [1:0] c;
        for (int k = 0; k < 4; k++) begin
            c = ptr + 2'(k);
            if (en[c]) return c;
        end
        return ptr;
    endfunction

    // Offer one word; returns after the accepting edge (+1). waits counts
    // cycles in_ready was low before acceptance.
    task automatic send(input logic [7:0] d, input bit track, output int waits);
        logic [1:0] t;
        bit         done;
        done  = 1'b0;
        waits = 0;
        in_data  = d;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                t = model_target(exp_ptr, ch_en);
                exp_ptr = t + 2'd1;
                if (track) sb_q.push_back('{ch: t, data: d});
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check_eq("send_bound", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 4'b0000);
        check_eq("rst_err", timeout_err, 1'b0);
        check_eq("rst_xfer", xfer_cnt, 16'd0);
        exp_ptr  = 2'd0;
        exp_xfer = 16'd0;
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every transfer that fires.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ((out_valid & out_ready) != 4'b0000)) begin
            if (sb_q.size() == 0) begin
                check_eq("fire_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("mon_valid", out_valid, 4'b0001 << e.ch);
                check_eq("mon_sel", sel, e.ch);
                check_eq("mon_data", out_data, e.data);
            end
            exp_xfer = exp_xfer + 16'd1;
        end
    end

    initial begin
        int   w;
        logic [7:0] stream [5];
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
        stream[3] = 8'h44; stream[4] = 8'h55;

        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        ch_en     = 4'b0000;
        out_ready = 4'b0000;
        #1;
        check_eq("reset_out_valid", out_valid, 4'b0000);
        check_eq("reset_out_data", out_data, 8'h00);
        check_eq("reset_sel", sel, 2'd0);
        check_eq("reset_xfer", xfer_cnt, 16'd0);
        check_eq("reset_err", timeout_err, 1'b0);
        check_eq("reset_in_ready", in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: full stream across all channels.
        ch_en     = 4'b1111;
        out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            send(stream[i], 1'b1, w);
            check_eq("t1_in_ready", w, 0);
            check_eq("t1_one_hot", out_valid, 4'b0001 << (i % 4));
        end
        idle(2);
        check_eq("t1_xfer", xfer_cnt, 16'd5);
        check_eq("t1_empty", out_valid, 4'b0000);

        // 2: sparse enable mask 1010 -> channels 1,3,1,3.
        ch_en = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            send(8'hA0 + 8'(i), 1'b1, w);
            check_eq("t2_sel", sel, (i % 2 == 0) ? 2'd1 : 2'd3);
        end
        idle(2);

        // 3: channel 1 not ready holds the word and blocks input.
        ch_en     = 4'b1111;
        out_ready = 4'b1101;
        send(8'hB0, 1'b1, w);
        send(8'hB1, 1'b1, w);
        check_eq("t3_held_ch1", out_valid, 4'b0010);
        in_data  = 8'hB2;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("t3_in_ready_low", in_ready, 1'b0);
            check_eq("t3_still_held", out_valid, 4'b0010);
            @(posedge clk);
            #1;
        end
        out_ready = 4'b1111;
        send(8'hB2, 1'b1, w);
        check_eq("t3_next_ch2", out_valid, 4'b0100);
        idle(2);

        // 4: timeout drop of a word nobody takes.
        out_ready = 4'b0000;
        send(8'hC0, 1'b0, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("t4_held", out_valid, 4'b1000);
            check_eq("t4_no_err", timeout_err, 1'b0);
        end
        @(negedge clk);
        check_eq("t4_dropped", out_valid, 4'b0000);
        check_eq("t4_err_pulse", timeout_err, 1'b1);
        @(negedge clk);
        check_eq("t4_err_once", timeout_err, 1'b0);
        check_eq("t4_xfer_unchanged", xfer_cnt, exp_xfer);
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        send(8'hC1, 1'b1, w);
        check_eq("t4_next_ch0", out_valid, 4'b0001);
        idle(2);

        // 5: reset while FULL, then first word to ch0.
        out_ready = 4'b0000;
        send(8'hD0, 1'b0, w);
        check_eq("t5_full", out_valid, 4'b0010);
        do_reset();
        out_ready = 4'b1111;
        send(8'hD1, 1'b1, w);
        check_eq("t5_first_ch0", out_valid, 4'b0001);
        idle(2);

        // 6: counter wrap, then disabled channels.
        do_reset();
        ch_en     = 4'b1111;
        out_ready = 4'b1111;
        for (int i = 0; i < 65534; i++) send(8'(i), 1'b1, w);
        idle(2);
        check_eq("t6_xfer_fffe", xfer_cnt, 16'hFFFE);
        send(8'hE0, 1'b1, w);
        send(8'hE1, 1'b1, w);
        idle(2);
        check_eq("t6_xfer_wrap", xfer_cnt, 16'h0000);

        // Held word completes even after its channel is disabled.
        out_ready = 4'b0000;
        send(8'hE2, 1'b1, w);
        ch_en = 4'b0000;
        @(negedge clk);
        check_eq("t6_commit_held", out_valid, 4'b0001 << (exp_ptr - 2'd1));
        check_eq("t6_in_ready_dis", in_ready, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 4'b1111;
        idle(2);
        in_valid = 1'b1;
        in_data  = 8'hE3;
        @(negedge clk);
        check_eq("t6_in_ready_off", in_ready, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(2);

        check_eq("sb_empty", sb_q.size(), 0);
        check_eq("final_xfer", xfer_cnt, exp_xfer);
        check_eq("final_no_err", timeout_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
